// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the two-master BRAM port arbiter.
//   state_e           : arbiter FSM states
//   WE_ALL / WE_NONE  : BRAM byte-write-enable patterns
//   BASE_ADDR_DEFAULT : default byte base address of the BRAM window
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RD_WAIT
    } state_e;

    localparam logic [3:0]  WE_ALL            = 4'b1111;
    localparam logic [3:0]  WE_NONE           = 4'b0000;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the requester handshakes (m0, m1) and the BRAM port B pins.
//   slave  : arbiter view (requests in, acks/read data/BRAM strobes out)
//   master : requester + BRAM model view (the mirror image)
interface bram_port_arbiter_if #(
    parameter int unsigned AW = 10
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata;
    logic          m0_ack;
    logic [31:0]   m0_rdata;
    logic          m0_rvalid;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic          m1_ack;
    logic [31:0]   m1_rdata;
    logic          m1_rvalid;

    logic [31:0]   addrb;
    logic          clkb;
    logic [31:0]   dinb;
    logic [31:0]   doutb;
    logic          enb;
    logic          rstb;
    logic [3:0]    web;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_rvalid,
        output addrb, clkb, dinb, enb, rstb, web,
        input  doutb
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_rvalid,
        input  addrb, clkb, dinb, enb, rstb, web,
        output doutb
    );

endinterface

// File: rtl/bram_port_arbiter_rr.sv
// Two-way round-robin selector.
//   req_i  : eligible requesters (bit N = mN)
//   last_i : index of the requester granted most recently
//   gnt_o  : one-hot grant; on contention the requester not granted last wins
module bram_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[0] && req_i[1]) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two requesters (m0, m1).
//   clk40 : sole clock, also forwarded as clkb
//   rst_n : asynchronous active-low reset
//   bus   : requester handshakes + BRAM port B (see bram_port_arbiter_if)
// One access at a time: IDLE grants, ACCESS strobes the BRAM for one cycle,
// reads then wait READ_LATENCY cycles in RD_WAIT before returning data.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
    parameter int unsigned AW           = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic               clk40,
    input  logic               rst_n,
    bram_port_arbiter_if.slave bus
);

    localparam logic [1:0] RL = 2'(READ_LATENCY);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;        // last granted requester; also routes read data
    logic        rst_done_q;
    logic        rd_q, rd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addrb_q, addrb_d;
    logic [31:0] dinb_q, dinb_d;
    logic        enb_q, enb_d;
    logic [3:0]  web_q, web_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;
    logic [AW+1:0] win_off;

    assign elig = {bus.m1_req & ~ack_q[1], bus.m0_req & ~ack_q[0]};

    bram_arb_rr u_rr (
        .req_i  (elig),
        .last_i (ptr_q),
        .gnt_o  (gnt)
    );

    assign win_we    = gnt[1] ? bus.m1_we    : bus.m0_we;
    assign win_addr  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
    assign win_wdata = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
    assign win_off   = {win_addr, 2'b00};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        addrb_d  = addrb_q;
        dinb_d   = dinb_q;
        enb_d    = 1'b0;
        web_d    = WE_NONE;
        ack_d    = '0;
        rvalid_d = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                // rst_done_q keeps the first edge after reset release grant-free
                if (rst_done_q && (gnt != 2'b00)) begin
                    state_d = ACCESS;
                    ptr_d   = gnt[1];
                    rd_d    = ~win_we;
                    addrb_d = BASE_ADDR + 32'(win_off);
                    dinb_d  = win_wdata;
                    enb_d   = 1'b1;
                    web_d   = win_we ? WE_ALL : WE_NONE;
                    ack_d   = gnt;
                end
            end
            ACCESS: begin
                if (rd_q) begin
                    state_d = RD_WAIT;
                    cnt_d   = 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == RL) begin
                    state_d = IDLE;
                    rvalid_d[ptr_q] = 1'b1;
                    if (ptr_q) rdata1_d = bus.doutb;
                    else       rdata0_d = bus.doutb;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b1;
            rst_done_q <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= '0;
            addrb_q    <= '0;
            dinb_q     <= '0;
            enb_q      <= 1'b0;
            web_q      <= WE_NONE;
            ack_q      <= '0;
            rvalid_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rst_done_q <= 1'b1;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            addrb_q    <= addrb_d;
            dinb_q     <= dinb_d;
            enb_q      <= enb_d;
            web_q      <= web_d;
            ack_q      <= ack_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.clkb      = clk40;
    assign bus.rstb      = 1'b0;
    assign bus.addrb     = addrb_q;
    assign bus.dinb      = dinb_q;
    assign bus.enb       = enb_q;
    assign bus.web       = web_q;
    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter BASE_ADDR, 32'h40000000, byte base address added to every requester word address.
REQ-002 Parameter AW, 10, requester word-address width.
REQ-003 Parameter READ_LATENCY, 1, BRAM cycles from enb strobe to valid doutb; legal range 1..3.
REQ-004 Ports, in order:
- clk40  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mN_req  in  1  access request, N in {0,1}; held stable with mN_we/mN_addr/mN_wdata until mN_ack.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  AW  word address.
- mN_wdata  in  32  write data.
- mN_ack  out  1  one-cycle pulse; request accepted and BRAM strobed this cycle.
- mN_rdata  out  32  read data, valid while mN_rvalid is high.
- mN_rvalid  out  1  one-cycle read-return pulse.
- addrb  out  32  BRAM byte address.
- clkb  out  1  BRAM clock.
- dinb  out  32  BRAM write data.
- doutb  in  32  BRAM read data.
- enb  out  1  BRAM enable.
- rstb  out  1  BRAM reset.
- web  out  4  BRAM byte write enables.

Function
REQ-005 clkb SHALL equal clk40; rstb SHALL be constant 0.
REQ-006 FSM states SHALL be IDLE, ACCESS, RD_WAIT.
REQ-007 A requester SHALL be eligible when mN_req=1 and mN_ack=0 in that cycle.
REQ-008 In IDLE, on an edge with any eligible requester, the FSM SHALL latch the winner's we/addr/wdata and enter ACCESS.
REQ-009 Arbitration SHALL be round-robin: with both eligible, the requester not granted last wins; the last-grant pointer updates only on a grant.
REQ-010 In ACCESS, registered outputs SHALL be: enb=1, addrb=BASE_ADDR+{addr,2'b00} (32-bit, wrap modulo 2^32), dinb=wdata, web=4'b1111 for write and 4'b0000 for read, winner's mN_ack=1.
REQ-011 ACCESS SHALL last exactly one cycle; a write then returns to IDLE, a read enters RD_WAIT.
REQ-012 With the access cycle at T, doutb SHALL be sampled at the end of cycle T+READ_LATENCY; mN_rdata updates and mN_rvalid=1 for that requester during cycle T+READ_LATENCY+1 only; FSM enters IDLE in that same cycle.
REQ-013 No grant SHALL occur in ACCESS or RD_WAIT; requests wait without loss.
REQ-014 Outside ACCESS, enb=0 and web=0; addrb and dinb SHALL hold their last values.
REQ-015 mN_rdata SHALL hold its value between reads; the other requester's rdata/rvalid SHALL be unaffected.
REQ-016 Throughput: back-to-back writes SHALL issue one access per two cycles; a read SHALL occupy READ_LATENCY+2 cycles.

Reset
REQ-017 rst_n low SHALL asynchronously force state IDLE, last-grant pointer to m1 (so m0 wins first), and addrb, dinb, enb, web, mN_ack, mN_rdata, mN_rvalid to 0.
REQ-018 Reset asserted during ACCESS or RD_WAIT SHALL abort the access; no mN_rvalid pulse for it SHALL occur after release.
REQ-019 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge of clk40.

Structure
REQ-020 Shared package bram_arb_pkg SHALL hold the state enum, WE_ALL = 4'b1111, WE_NONE = 4'b0000, and the BASE_ADDR default.
REQ-021 Round-robin selection SHALL live in sub-module bram_arb_rr (2 requests, pointer, grant one-hot); FSM and datapath stay in bram_port_arbiter.

Verification
REQ-022 m0 write addr=5, wdata=32'hDEADBEEF -> one cycle with enb=1, web=4'b1111, addrb=32'h40000014, dinb=32'hDEADBEEF, m0_ack=1.
REQ-023 m0 and m1 request writes in the same cycle after reset -> m0 acked first, m1 acked two cycles later; a further simultaneous pair is then granted m0 first again.
REQ-024 Model BRAM preloaded with word 3 = 32'h12345678, READ_LATENCY=1, m1 read addr=3 -> m1_ack at T, web=0, m1_rvalid=1 with m1_rdata=32'h12345678 at T+2, m0_rvalid stays 0.
REQ-025 m0 read pending while m1 requests a write -> no m1_ack before m0_rvalid; m1_ack in the cycle after m0_rvalid.
REQ-026 rst_n pulsed low during RD_WAIT -> all outputs 0 immediately, no rvalid afterwards, next request granted to m0.
REQ-027 READ_LATENCY=3, addr=2^AW-1 read -> addrb=32'h40000FFC, rvalid exactly 4 cycles after ack.
